// File: rtl/mips_pkg.sv
// Shared definitions for the memory-stage load/store unit.
package mips_pkg;

  // Access size encoding carried down the pipeline with each memory op
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Default data memory depth in 32-bit words
  localparam int DM_WORDS = 4096;

  // IDLE accepts requests; RMW_WR issues the write half of a sub-word store
  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane steering: extracts and extends load data, and merges
// sub-word store data into a fetched memory word.
module lsu_lane_align
  import mips_pkg::*;
#(
  parameter bit LITTLE_END = 1'b1
) (
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] field_mask;

  // Locate the lane bit offset, then extract/extend for loads and splice for stores
  always_comb begin
    shamt      = 5'd0;
    field_mask = 32'hFFFF_FFFF;
    if (size == SIZE_BYTE) begin
      shamt      = LITTLE_END ? {lane, 3'b000} : {~lane, 3'b000};
      field_mask = 32'h0000_00FF;
    end else if (size == SIZE_HALF) begin
      shamt      = LITTLE_END ? {lane[1], 4'b0000} : {~lane[1], 4'b0000};
      field_mask = 32'h0000_FFFF;
    end
    shifted = rdata >> shamt;
    case (size)
      SIZE_BYTE: ld_data = unsigned_ld ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: ld_data = unsigned_ld ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default:   ld_data = rdata;
    endcase
    merged = (rdata & ~(field_mask << shamt)) | ((wdata & field_mask) << shamt);
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage access controller: loads, word stores, read-modify-write
// sub-word stores with a one-cycle stall, and access fault detection.
module load_store_unit
  import mips_pkg::*;
#(
  parameter int MEM_WORDS  = DM_WORDS,
  parameter bit LITTLE_END = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        fault,
  output logic [31:0] bad_addr,
  output logic        dm_read,
  output logic        dm_write,
  output logic [31:0] dm_address,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  lsu_state_t  state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] bad_addr_q, bad_addr_d;

  logic [31:0] lane_ld_data;
  logic [31:0] lane_merged;
  logic        access_fault;

  lsu_lane_align #(.LITTLE_END(LITTLE_END)) u_lane_align (
    .rdata       (dm_rdata),
    .lane        (address[1:0]),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .wdata       (store_data),
    .ld_data     (lane_ld_data),
    .merged      (lane_merged)
  );

  // Reject reserved sizes, misaligned half/word accesses and out-of-range words
  always_comb begin
    access_fault = 1'b0;
    if (size == SIZE_RSVD)
      access_fault = 1'b1;
    else if (size == SIZE_HALF && address[0])
      access_fault = 1'b1;
    else if (size == SIZE_WORD && address[1:0] != 2'b00)
      access_fault = 1'b1;
    else if ({2'b00, address[31:2]} >= 32'(MEM_WORDS))
      access_fault = 1'b1;
  end

  // Next-state and output decode; everything is held quiet while reset is high
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bad_addr_d = bad_addr_q;
    load_data  = 32'd0;
    stall      = 1'b0;
    fault      = 1'b0;
    dm_read    = 1'b0;
    dm_write   = 1'b0;
    dm_address = 32'd0;
    dm_wdata   = 32'd0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (mem_read || mem_write) begin
            if (access_fault) begin
              fault      = 1'b1;
              bad_addr_d = address;
            end else if (mem_write) begin
              dm_address = {address[31:2], 2'b00};
              if (size == SIZE_WORD) begin
                dm_write = 1'b1;
                dm_wdata = store_data;
              end else begin
                stall   = 1'b1;
                dm_read = 1'b1;
                addr_d  = address[31:2];
                wdata_d = lane_merged;
                state_d = RMW_WR;
              end
            end else begin
              dm_read    = 1'b1;
              dm_address = {address[31:2], 2'b00};
              load_data  = lane_ld_data;
            end
          end
        end
        RMW_WR: begin
          dm_write   = 1'b1;
          dm_address = {addr_q, 2'b00};
          dm_wdata   = wdata_q;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, RMW latches and fault address register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 30'd0;
      wdata_q    <= 32'd0;
      bad_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign bad_addr = bad_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-addressed reference memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite, unsignedLd;
  logic [1:0]  size;
  logic [31:0] address, storeData;
  logic [31:0] loadData, badAddr, dmAddress, dmWdata, dmRdata;
  logic        stall, fault, dmRead, dmWrite;

  int testsRun = 0;
  int testsFailed = 0;

  // Data memory environment (what the DUT actually writes)
  logic [31:0] mem [0:4095];
  logic        pokeEn = 1'b0;
  int          pokeIdx = 0;
  logic [31:0] pokeVal = 32'd0;

  // Reference model: flat byte array, little-endian word packing
  logic [7:0]  refBytes [0:16383];
  logic [31:0] refBadAddr;

  // Expected outputs for the current cycle
  bit          expValid = 1'b0;
  logic [31:0] expLoad, expAddr, expWdata;
  logic        expStall, expFault, expDmRead, expDmWrite;

  // Values captured at the last sampling edge, for literal checks
  logic [31:0] sampLoad, sampWdata;
  logic        sampFault, sampStall;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (memRead),
    .mem_write   (memWrite),
    .size        (size),
    .unsigned_ld (unsignedLd),
    .address     (address),
    .store_data  (storeData),
    .load_data   (loadData),
    .stall       (stall),
    .fault       (fault),
    .bad_addr    (badAddr),
    .dm_read     (dmRead),
    .dm_write    (dmWrite),
    .dm_address  (dmAddress),
    .dm_wdata    (dmWdata),
    .dm_rdata    (dmRdata)
  );

  assign dmRdata = mem[dmAddress[13:2]];

  // Memory write port and preload path
  always @(posedge clk) begin
    if (dmWrite) mem[dmAddress[13:2]] <= dmWdata;
    else if (pokeEn) mem[pokeIdx] <= pokeVal;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] wordAt(input int w);
    return {refBytes[4*w+3], refBytes[4*w+2], refBytes[4*w+1], refBytes[4*w]};
  endfunction

  // Cycle-by-cycle comparison against the model's expectations
  always @(negedge clk) begin
    sampLoad  = loadData;
    sampWdata = dmWdata;
    sampFault = fault;
    sampStall = stall;
    if (expValid) begin
      checkOutput("load_data",  loadData,          expLoad);
      checkOutput("stall",      {31'd0, stall},    {31'd0, expStall});
      checkOutput("fault",      {31'd0, fault},    {31'd0, expFault});
      checkOutput("dm_read",    {31'd0, dmRead},   {31'd0, expDmRead});
      checkOutput("dm_write",   {31'd0, dmWrite},  {31'd0, expDmWrite});
      checkOutput("dm_address", dmAddress,         expAddr);
      checkOutput("dm_wdata",   dmWdata,           expWdata);
      checkOutput("bad_addr",   badAddr,           refBadAddr);
    end
  end

  task automatic preload(input int w, input logic [31:0] v);
    pokeIdx = w;
    pokeVal = v;
    pokeEn  = 1'b1;
    @(posedge clk);
    #1 pokeEn = 1'b0;
    {refBytes[4*w+3], refBytes[4*w+2], refBytes[4*w+1], refBytes[4*w]} = v;
  endtask

  task automatic setIdle();
    memRead = 1'b0; memWrite = 1'b0; size = 2'b10; unsignedLd = 1'b0;
    address = 32'd0; storeData = 32'd0;
    expLoad = 32'd0; expAddr = 32'd0; expWdata = 32'd0;
    expStall = 1'b0; expFault = 1'b0; expDmRead = 1'b0; expDmWrite = 1'b0;
  endtask

  // Drive one request, derive expectations from the byte model, and commit it
  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] addr, input logic [31:0] data);
    bit   bad;
    bit   rmw;
    int   a;
    logic [31:0] v;
    bad = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)
          || (addr / 4 >= 4096);
    rmw = 1'b0;
    a   = int'(addr[13:0]);
    setIdle();
    memRead = rd; memWrite = wr; size = sz; unsignedLd = uns; address = addr; storeData = data;
    if ((rd || wr) && bad) begin
      expFault = 1'b1;
    end else if (wr) begin
      expAddr = addr & 32'hFFFF_FFFC;
      if (sz == 2'b10) begin
        expDmWrite = 1'b1;
        expWdata   = data;
      end else begin
        expStall  = 1'b1;
        expDmRead = 1'b1;
        rmw       = 1'b1;
      end
    end else if (rd) begin
      expDmRead = 1'b1;
      expAddr   = addr & 32'hFFFF_FFFC;
      if (sz == 2'b00) begin
        v = {24'd0, refBytes[a]};
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
        v = {16'd0, refBytes[a+1], refBytes[a]};
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
        v = wordAt(a / 4);
      end
      expLoad = v;
    end
    expValid = 1'b1;
    @(posedge clk);
    #1;
    if ((rd || wr) && bad) refBadAddr = addr;
    else if (wr) begin
      refBytes[a] = data[7:0];
      if (sz != 2'b00) refBytes[a+1] = data[15:8];
      if (sz == 2'b10) begin
        refBytes[a+2] = data[23:16];
        refBytes[a+3] = data[31:24];
      end
    end
    if (rmw) begin
      expStall   = 1'b0;
      expDmRead  = 1'b0;
      expDmWrite = 1'b1;
      expWdata   = wordAt(a / 4);
      @(posedge clk);
      #1;
    end
    setIdle();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) refBytes[i] = 8'd0;
    refBadAddr = 32'd0;
    setIdle();
    rst = 1'b1;
    // Outputs must stay quiet under reset even with a request present
    memRead = 1'b1; address = 32'h4;
    preload(0, 32'h0000_0000);
    preload(1, 32'h8899_AABB);
    preload(2, 32'h0102_0304);
    preload(3, 32'h0000_0000);
    preload(4095, 32'h0000_0000);
    memRead = 1'b1; address = 32'h4;
    #1;
    checkOutput("rst_dm_read",   {31'd0, dmRead},  32'd0);
    checkOutput("rst_dm_addr",   dmAddress,        32'd0);
    checkOutput("rst_load_data", loadData,         32'd0);
    checkOutput("rst_bad_addr",  badAddr,          32'd0);
    setIdle();
    @(negedge clk);
    rst = 1'b0;
    expValid = 1'b1;
    @(posedge clk);
    #1;

    // Sub-word loads with sign and zero extension
    applyStimulus(1, 0, 2'b00, 0, 32'h5, 32'h0);
    checkOutput("lb_0x5_lit", sampLoad, 32'hFFFF_FFAA);
    applyStimulus(1, 0, 2'b00, 1, 32'h5, 32'h0);
    checkOutput("lbu_0x5_lit", sampLoad, 32'h0000_00AA);

    // Byte store by read-modify-write
    applyStimulus(0, 1, 2'b00, 0, 32'h6, 32'h0000_0011);
    checkOutput("sb_0x6_wdata_lit", sampWdata, 32'h8811_AABB);
    applyStimulus(1, 0, 2'b10, 0, 32'h4, 32'h0);
    checkOutput("lw_0x4_lit", sampLoad, 32'h8811_AABB);
    applyStimulus(1, 0, 2'b00, 0, 32'h7, 32'h0);
    checkOutput("lb_0x7_lit", sampLoad, 32'hFFFF_FF88);
    applyStimulus(1, 0, 2'b00, 1, 32'h4, 32'h0);
    checkOutput("lbu_0x4_lit", sampLoad, 32'h0000_00BB);

    // Half store and half loads
    applyStimulus(0, 1, 2'b01, 0, 32'h2, 32'h0000_CAFE);
    checkOutput("sh_0x2_mem_lit", mem[0], 32'hCAFE_0000);
    applyStimulus(1, 0, 2'b01, 0, 32'h2, 32'h0);
    checkOutput("lh_0x2_lit", sampLoad, 32'hFFFF_CAFE);
    applyStimulus(1, 0, 2'b01, 1, 32'h2, 32'h0);
    checkOutput("lhu_0x2_lit", sampLoad, 32'h0000_CAFE);

    // Back-to-back byte stores into the same word
    applyStimulus(0, 1, 2'b00, 0, 32'h0, 32'h0000_00AB);
    applyStimulus(0, 1, 2'b00, 0, 32'h1, 32'h0000_00CD);
    applyStimulus(1, 0, 2'b10, 0, 32'h0, 32'h0);
    checkOutput("b2b_sb_lit", sampLoad, 32'hCAFE_CDAB);

    // Faults and the last in-range word
    applyStimulus(1, 0, 2'b10, 0, 32'h6, 32'h0);
    checkOutput("lw_0x6_fault_lit", {31'd0, sampFault}, 32'd1);
    checkOutput("bad_addr_0x6_lit", badAddr, 32'h6);
    applyStimulus(0, 1, 2'b01, 0, 32'h1, 32'h0000_1234);
    applyStimulus(0, 1, 2'b10, 0, 32'h3FFC, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 2'b10, 0, 32'h3FFC, 32'h0);
    checkOutput("lw_0x3ffc_lit", sampLoad, 32'hDEAD_BEEF);
    applyStimulus(0, 1, 2'b10, 0, 32'h4000, 32'h5555_5555);
    checkOutput("bad_addr_0x4000_lit", badAddr, 32'h4000);

    // Reset during the write cycle of a byte store drops the write
    expValid = 1'b0;
    memWrite = 1'b1; size = 2'b00; address = 32'h8; storeData = 32'h77;
    @(negedge clk);
    checkOutput("rstrmw_c0_stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstrmw_dm_write", {31'd0, dmWrite}, 32'd0);
    checkOutput("rstrmw_stall",    {31'd0, stall},   32'd0);
    checkOutput("rstrmw_bad_addr", badAddr,          32'd0);
    setIdle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    refBadAddr = 32'd0;
    checkOutput("rstrmw_mem2_lit", mem[2], 32'h0102_0304);
    applyStimulus(1, 0, 2'b10, 0, 32'h8, 32'h0);
    checkOutput("rstrmw_lw_0x8_lit", sampLoad, 32'h0102_0304);

    // Simultaneous read and write acts as a store; reserved size faults
    applyStimulus(1, 1, 2'b10, 0, 32'hC, 32'h1234_5678);
    checkOutput("rdwr_load_data_lit", sampLoad, 32'd0);
    checkOutput("rdwr_mem3_lit", mem[3], 32'h1234_5678);
    applyStimulus(1, 0, 2'b10, 0, 32'hC, 32'h0);
    checkOutput("lw_0xc_lit", sampLoad, 32'h1234_5678);
    applyStimulus(1, 0, 2'b11, 0, 32'h0, 32'h0);
    checkOutput("rsvd_fault_lit", {31'd0, sampFault}, 32'd1);
    checkOutput("rsvd_stall_lit", {31'd0, sampStall}, 32'd0);

    @(posedge clk);
    @(posedge clk);
    expValid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
